// File: rtl/sparrow_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory req/gnt/rvalid port and
// the valid/ready instruction stream to decode.
interface sparrow_fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output o_instr_valid, o_instr, o_instr_pc,
        input  i_instr_ready
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  o_instr_valid, o_instr, o_instr_pc,
        output i_instr_ready
    );
endinterface

// File: rtl/sparrow_fetch_unit.sv
// Sparrow instruction fetch: PC, credit-limited imem requests, response FIFO.
// Optional misaligned-redirect halt: define SPARROW_FETCH_MISALIGN_CHECK_EN.
module sparrow_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_redirect_valid,
    input  logic [31:0]          i_redirect_pc,
`ifdef SPARROW_FETCH_MISALIGN_CHECK_EN
    output logic                 o_fetch_misaligned,
`endif
    sparrow_fetch_unit_if.master bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1
`ifdef SPARROW_FETCH_MISALIGN_CHECK_EN
        ,
        HALT  = 2'd2
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;

    logic [31:0]   pq [FIFO_DEPTH];
    logic [AW-1:0] pq_wr, pq_rd;

    logic [31:0]   f_instr [FIFO_DEPTH];
    logic [31:0]   f_pc    [FIFO_DEPTH];
    logic [AW-1:0] f_wr, f_rd;
    logic [CW-1:0] f_cnt;

    logic          rsp, credit, req, grant, push, pop;
    logic [CW:0]   inflight;

    assign rsp      = bus.i_imem_rvalid && (out_q != '0);
    assign inflight = {1'b0, out_q} + {1'b0, f_cnt};
    assign credit   = inflight < (CW+1)'(FIFO_DEPTH);
    assign req      = i_rst_n && (state_q == FETCH)
                    && !i_redirect_valid && credit;
    assign grant    = req && bus.i_imem_gnt;
    // Responses only reach the FIFO in FETCH; DRAIN/HALT drop them.
    assign push     = (state_q == FETCH) && !i_redirect_valid && rsp;
    assign pop      = (f_cnt != '0) && bus.i_instr_ready;
    assign out_d    = out_q + CW'(grant) - CW'(rsp);

    assign bus.o_imem_req    = req;
    assign bus.o_imem_addr   = pc_q;
    assign bus.o_instr_valid = (f_cnt != '0);
    assign bus.o_instr       = f_instr[f_rd];
    assign bus.o_instr_pc    = f_pc[f_rd];

`ifdef SPARROW_FETCH_MISALIGN_CHECK_EN
    assign o_fetch_misaligned = (state_q == HALT);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (i_redirect_valid) begin
            pc_d    = {i_redirect_pc[31:2], 2'b00};
            state_d = (out_d != '0) ? DRAIN : FETCH;
`ifdef SPARROW_FETCH_MISALIGN_CHECK_EN
            if (i_redirect_pc[1:0] != 2'b00) begin
                pc_d    = i_redirect_pc;
                state_d = HALT;
            end
`endif
        end else begin
            unique case (state_q)
                FETCH: if (grant) pc_d = pc_q + 32'd4;
                DRAIN: if (out_d == '0) state_d = FETCH;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pq_wr <= '0;
            pq_rd <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) pq[i] <= '0;
        end else if (i_redirect_valid) begin
            pq_wr <= '0;
            pq_rd <= '0;
        end else begin
            if (grant) begin
                pq[pq_wr] <= pc_q;
                pq_wr     <= pq_wr + AW'(1);
            end
            if (push) pq_rd <= pq_rd + AW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            f_wr  <= '0;
            f_rd  <= '0;
            f_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                f_instr[i] <= '0;
                f_pc[i]    <= '0;
            end
        end else if (i_redirect_valid) begin
            f_wr  <= '0;
            f_rd  <= '0;
            f_cnt <= '0;
        end else begin
            if (push) begin
                f_instr[f_wr] <= bus.i_imem_rdata;
                f_pc[f_wr]    <= pq[pq_rd];
                f_wr          <= f_wr + AW'(1);
            end
            if (pop) f_rd <= f_rd + AW'(1);
            f_cnt <= f_cnt + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_sparrow_fetch_unit.sv
// Randomized bench for sparrow_fetch_unit: queue-based fetch model,
// in-order memory responder and directed redirect/back-pressure scenarios.
module tb_sparrow_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redir;
    logic [31:0] rpc;
`ifdef SPARROW_FETCH_MISALIGN_CHECK_EN
    logic        mis;
`endif

    sparrow_fetch_unit_if bus ();

    sparrow_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_redirect_valid (redir),
        .i_redirect_pc    (rpc),
`ifdef SPARROW_FETCH_MISALIGN_CHECK_EN
        .o_fetch_misaligned (mis),
`endif
        .bus              (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    mreq_t       memq[$];
    ent_t        fq[$];
    logic [31:0] pq[$];
    int          m_st;
    logic [31:0] m_pc;
    int          m_out;

    int cyc, lat_min, lat_max, rv_pct;
    int checks, errors;

    bit          obs_req, obs_valid, obs_mis, obs_rv, granted;
    logic [31:0] obs_addr, obs_instr, obs_ipc;
    bit          exp_req, exp_valid, exp_mis;
    logic [31:0] exp_addr, exp_instr, exp_ipc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic bit is_mis(input logic [31:0] t);
`ifdef SPARROW_FETCH_MISALIGN_CHECK_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        redir = 0; rpc = 0;
        bus.i_instr_ready = 0; bus.i_imem_gnt = 0;
        bus.i_imem_rvalid = 0; bus.i_imem_rdata = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        m_st = 0; m_pc = 32'h0; m_out = 0;
        fq.delete(); pq.delete(); memq.delete();
        @(posedge clk); #1;
        cyc++;
    endtask

    // One clock: drive inputs, sample DUT, run the fetch model one cycle.
    task automatic step(input bit rd, input logic [31:0] tgt,
                        input bit rdy, input int gpct);
        bit rv, g, rsp, pop, mgr;
        logic [31:0] rdata;
        rv = memq.size() > 0 && memq[0].due <= cyc
           && $urandom_range(0, 99) < rv_pct;
        rdata = rv ? word_of(memq[0].addr) : $urandom;
        redir = rd; rpc = tgt; bus.i_instr_ready = rdy;
        bus.i_imem_rvalid = rv; bus.i_imem_rdata = rdata;
        bus.i_imem_gnt = 0;
        #1;
        obs_req = bus.o_imem_req; obs_addr = bus.o_imem_addr;
        obs_valid = bus.o_instr_valid; obs_instr = bus.o_instr;
        obs_ipc = bus.o_instr_pc; obs_rv = rv;
`ifdef SPARROW_FETCH_MISALIGN_CHECK_EN
        obs_mis = mis;
`else
        obs_mis = 0;
`endif
        g = $urandom_range(0, 99) < gpct;
        bus.i_imem_gnt = g;
        #1;
        exp_req = m_st == 0 && !rd && (m_out + fq.size() < DEPTH);
        exp_addr = m_pc;
        exp_valid = fq.size() != 0;
        exp_instr = exp_valid ? fq[0].instr : 32'h0;
        exp_ipc = exp_valid ? fq[0].pc : 32'h0;
        exp_mis = m_st == 2;
        granted = obs_req && g;
        if (granted)
            memq.push_back('{obs_addr, cyc + 1 + $urandom_range(lat_min, lat_max)});
        if (rv) void'(memq.pop_front());
        rsp = rv && m_out > 0;
        pop = exp_valid && rdy;
        mgr = exp_req && g;
        if (rd) begin
            if (rsp) m_out--;
            fq.delete(); pq.delete();
            m_pc = is_mis(tgt) ? tgt : {tgt[31:2], 2'b00};
            m_st = is_mis(tgt) ? 2 : (m_out > 0 ? 1 : 0);
        end else if (m_st == 0) begin
            if (pop) void'(fq.pop_front());
            if (rsp) begin
                m_out--;
                fq.push_back('{rdata, pq.pop_front()});
            end
            if (mgr) begin
                pq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
                m_out++;
            end
        end else begin
            if (rsp) m_out--;
            if (m_st == 1 && m_out == 0) m_st = 0;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 0; redir = 0; rpc = 0;
        bus.i_instr_ready = 0; bus.i_imem_gnt = 0;
        bus.i_imem_rvalid = 0; bus.i_imem_rdata = 0;
        #2;
        checks++;
        if (bus.o_imem_req !== 1'b0 || bus.o_instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl req=%b valid=%b want 0/0",
                     bus.o_imem_req, bus.o_instr_valid);
        end
        checks++;
        if (bus.o_imem_addr !== 32'h0 || bus.o_instr !== 32'h0
            || bus.o_instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_data addr=%h instr=%h pc=%h want 0",
                     bus.o_imem_addr, bus.o_instr, bus.o_instr_pc);
        end
`ifdef SPARROW_FETCH_MISALIGN_CHECK_EN
        checks++;
        if (mis !== 1'b0) begin
            errors++;
            $display("FAIL reset_mis got %b want 0", mis);
        end
`endif
        do_reset();
        lat_min = 0; lat_max = 0; rv_pct = 100;
        memq.push_back('{32'h0000_0120, 0});
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1) begin
            errors++;
            $display("FAIL stray_rvalid valid=%b req=%b want 0/1",
                     obs_valid, obs_req);
        end
    endtask

    task automatic test_stream();
        int first_g, first_v, hs;
        logic [31:0] g_next, v_next;
        do_reset();
        lat_min = 0; lat_max = 0; rv_pct = 100;
        first_g = -1; first_v = -1; hs = 0;
        g_next = 0; v_next = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 1, 100);
            checks++;
            if (obs_req !== exp_req || obs_addr !== exp_addr) begin
                errors++;
                $display("FAIL stream_req c%0d req=%b addr=%h want %b/%h",
                         i, obs_req, obs_addr, exp_req, exp_addr);
            end
            if (granted) begin
                if (first_g < 0) first_g = i;
                checks++;
                if (obs_addr !== g_next) begin
                    errors++;
                    $display("FAIL stream_gaddr got %h want %h",
                             obs_addr, g_next);
                end
                g_next += 4;
            end
            if (obs_valid) begin
                if (first_v < 0) first_v = i;
                hs++;
                checks++;
                if (obs_ipc !== v_next || obs_instr !== word_of(v_next)) begin
                    errors++;
                    $display("FAIL stream_out pc=%h instr=%h want %h/%h",
                             obs_ipc, obs_instr, v_next, word_of(v_next));
                end
                v_next += 4;
            end
        end
        checks++;
        if (first_v - first_g != 2 || hs < 8) begin
            errors++;
            $display("FAIL stream_latency got %0d hs=%0d want 2 hs>=8",
                     first_v - first_g, hs);
        end
    endtask

    task automatic test_backpressure();
        int gcnt;
        bit seen8;
        do_reset();
        lat_min = 0; lat_max = 0; rv_pct = 100;
        gcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 100);
            if (granted) gcnt++;
            if (i >= 3) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_ipc !== 32'h0
                    || obs_instr !== word_of(32'h0) || obs_req !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold v=%b pc=%h req=%b want 1/0/0",
                             obs_valid, obs_ipc, obs_req);
                end
            end
        end
        checks++;
        if (gcnt != DEPTH) begin
            errors++;
            $display("FAIL bp_grants got %0d want %0d", gcnt, DEPTH);
        end
        seen8 = 0;
        for (int i = 0; i < 4 && !seen8; i++) begin
            step(0, 0, 1, 100);
            if (granted) begin
                seen8 = 1;
                checks++;
                if (obs_addr !== 32'h8) begin
                    errors++;
                    $display("FAIL bp_resume got %h want 00000008", obs_addr);
                end
            end
        end
        checks++;
        if (!seen8) begin
            errors++;
            $display("FAIL bp_resume_timeout got none want grant");
        end
    endtask

    task automatic drain_run(input logic [31:0] t1, input bit second,
                             input logic [31:0] t2, input string tag);
        int quiet;
        bit hit;
        do_reset();
        lat_min = 3; lat_max = 3; rv_pct = 100;
        step(0, 0, 1, 100);
        step(0, 0, 1, 100);
        step(1, t1, 1, 100);
        quiet = 0; hit = 0;
        if (second) begin
            step(1, t2, 1, 100);
            quiet = 1;
        end
        for (int i = 0; i < 12 && !hit; i++) begin
            step(0, 0, 1, 100);
            checks++;
            if (obs_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_stale pc=%h want no valid", tag, obs_ipc);
            end
            if (granted) hit = 1;
            else quiet++;
        end
        checks++;
        if (!hit || obs_addr !== (second ? t2 : t1) || quiet != 3) begin
            errors++;
            $display("FAIL %s_restart addr=%h quiet=%0d want %h/3",
                     tag, obs_addr, quiet, second ? t2 : t1);
        end
    endtask

    task automatic test_redirect_drain();
        drain_run(32'h0000_1000, 0, 32'h0, "drain");
        drain_run(32'h0000_1000, 1, 32'h0000_2000, "drain2");
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        lat_min = 0; lat_max = 0; rv_pct = 100;
        step(0, 0, 1, 100);
        step(0, 0, 1, 100);
        step(1, 32'h0000_4000, 1, 100);
        checks++;
        if (obs_valid !== 1'b1 || obs_rv !== 1'b1) begin
            errors++;
            $display("FAIL redir_setup valid=%b rvalid=%b want 1/1",
                     obs_valid, obs_rv);
        end
        step(0, 0, 1, 100);
        checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1
            || obs_addr !== 32'h0000_4000) begin
            errors++;
            $display("FAIL redir_coincide v=%b req=%b addr=%h want 0/1/4000",
                     obs_valid, obs_req, obs_addr);
        end
        step(0, 0, 1, 100);
        step(0, 0, 1, 100);
        checks++;
        if (obs_valid !== 1'b1 || obs_ipc !== 32'h0000_4000) begin
            errors++;
            $display("FAIL redir_first v=%b pc=%h want 1/00004000",
                     obs_valid, obs_ipc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        int n;
        do_reset();
        lat_min = 0; lat_max = 0; rv_pct = 100;
        step(1, 32'hFFFF_FFFC, 1, 100);
        want = 32'hFFFF_FFFC; n = 0;
        for (int i = 0; i < 8 && n < 2; i++) begin
            step(0, 0, 1, 100);
            if (granted) begin
                checks++;
                if (obs_addr !== want) begin
                    errors++;
                    $display("FAIL wrap_addr got %h want %h", obs_addr, want);
                end
                want += 4; n++;
            end
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL wrap_timeout got %0d grants want 2", n);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        lat_min = 0; lat_max = 0; rv_pct = 100;
        step(1, 32'h0000_1002, 1, 100);
`ifdef SPARROW_FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 100);
            checks++;
            if (obs_mis !== 1'b1 || obs_req !== 1'b0) begin
                errors++;
                $display("FAIL halt mis=%b req=%b want 1/0", obs_mis, obs_req);
            end
        end
        step(1, 32'h0000_3000, 1, 100);
        step(0, 0, 1, 100);
        checks++;
        if (obs_mis !== 1'b0 || obs_req !== 1'b1
            || obs_addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL halt_exit mis=%b req=%b addr=%h want 0/1/3000",
                     obs_mis, obs_req, obs_addr);
        end
`else
        step(0, 0, 1, 100);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL misalign_clear req=%b addr=%h want 1/1000",
                     obs_req, obs_addr);
        end
`endif
    endtask

    task automatic test_random();
        bit rd;
        logic [31:0] tgt;
        do_reset();
        lat_min = 0; lat_max = 3; rv_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 0;
                #1;
                checks++;
                if (bus.o_instr_valid !== 1'b0 || bus.o_imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL async_rst v=%b req=%b want 0/0",
                             bus.o_instr_valid, bus.o_imem_req);
                end
                do_reset();
            end
            rd = $urandom_range(0, 39) == 0;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step(rd, tgt, $urandom_range(0, 99) < 60, 70);
            checks++;
            if (obs_req !== exp_req || obs_addr !== exp_addr
                || obs_valid !== exp_valid || obs_mis !== exp_mis) begin
                errors++;
                $display("FAIL rnd_ctl c%0d req=%b addr=%h v=%b m=%b want %b/%h/%b/%b",
                         i, obs_req, obs_addr, obs_valid, obs_mis,
                         exp_req, exp_addr, exp_valid, exp_mis);
            end
            if (exp_valid) begin
                checks++;
                if (obs_instr !== exp_instr || obs_ipc !== exp_ipc) begin
                    errors++;
                    $display("FAIL rnd_data c%0d instr=%h pc=%h want %h/%h",
                             i, obs_instr, obs_ipc, exp_instr, exp_ipc);
                end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        lat_min = 0; lat_max = 0; rv_pct = 100;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_rvalid();
        test_wrap();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
